// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with jump, call/return stack and relative branch
//
// Purpose:
//   Registered program counter that advances every cycle. It can also jump,
//   call (pushing a return address), return (popping one) or branch by a
//   sign-magnitude offset. The return-address stack holds RAS_DEPTH entries.
//   A call made while the stack is full drops the oldest entry. A return made
//   while the stack is empty increments the PC instead. Both cases pulse wRasError.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   synchronous active-high reset
//   wStall        in   hold all state, ignore control inputs
//   wJumpTaken    in   absolute jump to wJumpAddress
//   wCall         in   absolute jump to wJumpAddress, push wIP+1
//   wReturn       in   pop return stack into wIP
//   wBranchTaken  in   relative branch by wBranchOffset
//   wJumpAddress  in   [ADDR_W] jump/call target
//   wBranchOffset in   [OFF_W]  sign-magnitude offset, MSB set = backward
//   wIP           out  [ADDR_W] current program counter
//   wRasEmpty     out  stack holds no entries
//   wRasFull      out  stack holds RAS_DEPTH entries
//   wRasError     out  one-cycle pulse on overflow or underflow

module pc_sequencer #(
    parameter int                ADDR_W       = 10,
    parameter int                OFF_W        = 6,
    parameter int                RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wStall,
    input  logic              wJumpTaken,
    input  logic              wCall,
    input  logic              wReturn,
    input  logic              wBranchTaken,
    input  logic [ADDR_W-1:0] wJumpAddress,
    input  logic [OFF_W-1:0]  wBranchOffset,
    output logic [ADDR_W-1:0] wIP,
    output logic              wRasEmpty,
    output logic              wRasFull,
    output logic              wRasError
);

    localparam int              CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    // Entry 0 is the top of the stack. A push shifts toward the higher indices,
    // so when the stack is full the oldest entry falls off the far end.
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [CNT_W-1:0]  ras_cnt;

    logic [ADDR_W-1:0] ip_inc;
    logic [ADDR_W-1:0] ip_next;
    logic [ADDR_W-1:0] br_mag;
    logic [CNT_W-1:0]  cnt_next;
    logic              do_push;
    logic              do_pop;
    logic              err_next;

    always_comb begin
        ip_inc   = wIP + 1'b1;
        br_mag   = ADDR_W'(wBranchOffset[OFF_W-2:0]);
        ip_next  = ip_inc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        err_next = 1'b0;
        if (wJumpTaken) begin
            ip_next = wJumpAddress;
        end else if (wCall) begin
            ip_next  = wJumpAddress;
            do_push  = 1'b1;
            err_next = (ras_cnt == FULL_CNT);
        end else if (wReturn) begin
            if (ras_cnt == '0) begin
                // Underflow: behave like a plain increment.
                err_next = 1'b1;
            end else begin
                ip_next = ras[0];
                do_pop  = 1'b1;
            end
        end else if (wBranchTaken) begin
            ip_next = wBranchOffset[OFF_W-1] ? (wIP - br_mag) : (wIP + br_mag);
        end
    end

    always_comb begin
        cnt_next = ras_cnt;
        if (do_push && (ras_cnt != FULL_CNT)) begin
            cnt_next = ras_cnt + 1'b1;
        end else if (do_pop) begin
            cnt_next = ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wIP       <= RESET_VECTOR;
            ras_cnt   <= '0;
            wRasEmpty <= 1'b1;
            wRasFull  <= 1'b0;
            wRasError <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (wStall) begin
            wRasError <= 1'b0;
        end else begin
            wIP       <= ip_next;
            ras_cnt   <= cnt_next;
            wRasEmpty <= (cnt_next == '0);
            wRasFull  <= (cnt_next == FULL_CNT);
            wRasError <= err_next;
            if (do_push) begin
                ras[0] <= ip_inc;
                for (int i = 1; i < RAS_DEPTH; i++) begin
                    ras[i] <= ras[i-1];
                end
            end else if (do_pop) begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    ras[i] <= ras[i+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
//
// Purpose:
//   Drives directed scenarios first and then random traffic. Every cycle is
//   compared against a reference model that uses an integer PC and a queue as
//   the return stack. Directed steps also compare against known constant results.
//
// Ports: none (top-level bench)

module tb_pc_sequencer;

    localparam int ADDR_W = 10;
    localparam int OFF_W  = 6;
    localparam int DEPTH  = 4;
    localparam int MODN   = 1 << ADDR_W;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              wStall = 1'b0;
    logic              wJumpTaken = 1'b0;
    logic              wCall = 1'b0;
    logic              wReturn = 1'b0;
    logic              wBranchTaken = 1'b0;
    logic [ADDR_W-1:0] wJumpAddress = '0;
    logic [OFF_W-1:0]  wBranchOffset = '0;
    logic [ADDR_W-1:0] wIP;
    logic              wRasEmpty;
    logic              wRasFull;
    logic              wRasError;

    pc_sequencer #(
        .ADDR_W(ADDR_W),
        .OFF_W(OFF_W),
        .RAS_DEPTH(DEPTH),
        .RESET_VECTOR('0)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .wStall(wStall),
        .wJumpTaken(wJumpTaken),
        .wCall(wCall),
        .wReturn(wReturn),
        .wBranchTaken(wBranchTaken),
        .wJumpAddress(wJumpAddress),
        .wBranchOffset(wBranchOffset),
        .wIP(wIP),
        .wRasEmpty(wRasEmpty),
        .wRasFull(wRasFull),
        .wRasError(wRasError)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_ip  = 0;
    int m_stk[$];
    bit m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit stall, input bit j, input bit c,
                              input bit r, input bit b, input int ja, input int off);
        int mag;
        if (rst) begin
            m_ip = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else if (stall) begin
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (j) begin
                m_ip = ja;
            end else if (c) begin
                m_stk.push_front((m_ip + 1) % MODN);
                if (m_stk.size() > DEPTH) begin
                    void'(m_stk.pop_back());
                    m_err = 1'b1;
                end
                m_ip = ja;
            end else if (r) begin
                if (m_stk.size() == 0) begin
                    m_ip  = (m_ip + 1) % MODN;
                    m_err = 1'b1;
                end else begin
                    m_ip = m_stk.pop_front();
                end
            end else if (b) begin
                mag = off % (1 << (OFF_W - 1));
                if (off >= (1 << (OFF_W - 1)))
                    m_ip = (m_ip - mag + MODN) % MODN;
                else
                    m_ip = (m_ip + mag) % MODN;
            end else begin
                m_ip = (m_ip + 1) % MODN;
            end
        end
    endtask

    // One clock: apply inputs, clock, update the model, compare all outputs.
    task automatic cyc(input bit rst, input bit stall, input bit j, input bit c,
                       input bit r, input bit b, input int ja, input int off);
        Reset         = rst;
        wStall        = stall;
        wJumpTaken    = j;
        wCall         = c;
        wReturn       = r;
        wBranchTaken  = b;
        wJumpAddress  = ADDR_W'(ja);
        wBranchOffset = OFF_W'(off);
        @(posedge Clock);
        #1;
        model_step(rst, stall, j, c, r, b, ja, off);
        chk("ip",    32'(wIP),       32'(m_ip));
        chk("empty", 32'(wRasEmpty), 32'(m_stk.size() == 0));
        chk("full",  32'(wRasFull),  32'(m_stk.size() == DEPTH));
        chk("error", 32'(wRasError), 32'(m_err));
    endtask

    task automatic idle();      cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic jump(input int a); cyc(0, 0, 1, 0, 0, 0, a, 0); endtask
    task automatic call(input int a); cyc(0, 0, 0, 1, 0, 0, a, 0); endtask
    task automatic ret();       cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic br(input int o);   cyc(0, 0, 0, 0, 0, 1, 0, o); endtask

    initial begin
        // Reset and idle counting
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ip", 32'(wIP), 0);
        chk("rst_empty", 32'(wRasEmpty), 1);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("idle_ip", 32'(wIP), 32'(i));
        end
        chk("idle_empty", 32'(wRasEmpty), 1);

        // Branches backward and forward, plus zero offsets
        jump(20);
        br(6'b100011);
        chk("br_back", 32'(wIP), 17);
        br(6'b000100);
        chk("br_fwd", 32'(wIP), 21);
        br(6'b000000);
        chk("br_pz", 32'(wIP), 21);
        br(6'b100000);
        chk("br_mz", 32'(wIP), 21);

        // Wrap-around
        jump(3);
        br(6'b100101);
        chk("br_wrap", 32'(wIP), 1022);
        jump(1023);
        idle();
        chk("inc_wrap", 32'(wIP), 0);

        // Nested call / return
        jump(10);
        call(100);
        chk("call1", 32'(wIP), 100);
        call(200);
        chk("call2", 32'(wIP), 200);
        ret();
        chk("ret1", 32'(wIP), 101);
        ret();
        chk("ret2", 32'(wIP), 11);
        chk("ret2_empty", 32'(wRasEmpty), 1);

        // Overflow then underflow
        jump(10);
        call(100);
        chk("ovf_err0", 32'(wRasError), 0);
        call(200);
        call(300);
        call(400);
        chk("ovf_full", 32'(wRasFull), 1);
        chk("ovf_err3", 32'(wRasError), 0);
        call(500);
        chk("ovf_err", 32'(wRasError), 1);
        chk("ovf_full2", 32'(wRasFull), 1);
        ret();
        chk("lifo0", 32'(wIP), 401);
        chk("lifo0_err", 32'(wRasError), 0);
        ret();
        chk("lifo1", 32'(wIP), 301);
        ret();
        chk("lifo2", 32'(wIP), 201);
        ret();
        chk("lifo3", 32'(wIP), 101);
        chk("lifo_empty", 32'(wRasEmpty), 1);
        ret();
        chk("unf_ip", 32'(wIP), 102);
        chk("unf_err", 32'(wRasError), 1);
        idle();
        chk("unf_clear", 32'(wRasError), 0);

        // Stall with jump held, jump beats call, reset beats stall
        jump(700);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 55, 0);
            chk("stall_ip", 32'(wIP), 700);
        end
        call(5);
        cyc(0, 0, 1, 1, 0, 0, 900, 0);
        chk("jmp_win", 32'(wIP), 900);
        ret();
        chk("jmp_win_stack", 32'(wIP), 701);
        chk("jmp_win_empty", 32'(wRasEmpty), 1);
        call(44);
        cyc(1, 0, 0, 1, 0, 0, 300, 0);
        chk("rst_mid_call", 32'(wIP), 0);
        chk("rst_mid_call_empty", 32'(wRasEmpty), 1);
        jump(123);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_stall", 32'(wIP), 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, MODN - 1)),
                int'($urandom_range(0, 63)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter OFF_W, default 6, giving the sign-magnitude branch offset width: bit OFF_W-1 is the sign (1 = backward) and bits OFF_W-2:0 are the magnitude.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4 (range 2..16), giving the number of return-address stack entries.
REQ-004 The block SHALL have parameter RESET_VECTOR, default 0, an ADDR_W-bit value that is the PC after reset.
REQ-005 Clock  input  1  system clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 wStall  input  1  when high, all state holds and every control input is ignored.
REQ-008 wJumpTaken  input  1  absolute jump to wJumpAddress.
REQ-009 wCall  input  1  absolute jump to wJumpAddress that also pushes the return address.
REQ-010 wReturn  input  1  pop the return-address stack and jump to the popped address.
REQ-011 wBranchTaken  input  1  PC-relative branch by wBranchOffset.
REQ-012 wJumpAddress  input  ADDR_W  target for jump and call.
REQ-013 wBranchOffset  input  OFF_W  sign-magnitude relative offset.
REQ-014 wIP  output  ADDR_W  registered current program counter.
REQ-015 wRasEmpty  output  1  registered flag, high when the stack holds 0 entries.
REQ-016 wRasFull  output  1  registered flag, high when the stack holds RAS_DEPTH entries.
REQ-017 wRasError  output  1  registered one-cycle pulse on stack overflow or underflow.

Function
REQ-018 The block SHALL evaluate the following priority every rising edge and act on the first match only: Reset > wStall > wJumpTaken > wCall > wReturn > wBranchTaken > increment.
REQ-019 Increment SHALL set wIP <= wIP + 1, wrapping modulo 2^ADDR_W (all ones -> 0).
REQ-020 Jump SHALL set wIP <= wJumpAddress and SHALL leave the stack unchanged.
REQ-021 Call SHALL set wIP <= wJumpAddress and SHALL push (wIP + 1) mod 2^ADDR_W onto the stack.
REQ-022 Return SHALL set wIP to the top stack entry and remove that entry.
REQ-023 Branch SHALL set wIP <= wIP - magnitude when the sign bit is 1, and wIP <= wIP + magnitude when the sign bit is 0.
REQ-024 For branches, the magnitude SHALL be zero-extended to ADDR_W and the result SHALL wrap modulo 2^ADDR_W.
REQ-025 A branch offset of +0 or -0 SHALL leave wIP unchanged for that cycle.
REQ-026 All targets SHALL take effect in wIP on the same edge that samples the request; there is no delay slot.
REQ-027 A call while the stack is full SHALL discard the oldest entry, push the new entry, leave wRasFull high, and pulse wRasError.
REQ-028 A return while the stack is empty SHALL perform an increment instead, leave the stack unchanged, and pulse wRasError.
REQ-029 While wStall is high, wIP, the stack contents and both stack flags SHALL hold, and wRasError SHALL be 0.
REQ-030 wRasError SHALL be 0 in every cycle that has no overflow or underflow event.
REQ-031 wRasFull and wRasEmpty SHALL reflect the stack occupancy after the update of the same edge.

Reset
REQ-032 Reset high at a rising edge SHALL set wIP = RESET_VECTOR, empty the stack, and set wRasEmpty = 1, wRasFull = 0, wRasError = 0.
REQ-033 Reset SHALL override wStall and all control inputs in the same cycle, including when asserted mid-call or mid-stall.
REQ-034 Outputs SHALL be undefined until the first reset edge.

Verification
REQ-035 Reset, then 5 idle cycles -> wIP steps 0,1,2,3,4,5; wRasEmpty = 1.
REQ-036 At wIP = 20: branch with offset 6'b100011 -> wIP = 17; then branch with 6'b000100 -> wIP = 21.
REQ-037 At wIP = 3: branch with -5 (6'b100101) -> wIP = 1022; at wIP = 1023: increment -> wIP = 0.
REQ-038 At wIP = 10: call 100 -> wIP = 100; call 200 -> wIP = 200; return -> wIP = 101; return -> wIP = 11 with wRasEmpty = 1.
REQ-039 With RAS_DEPTH = 4: five nested calls -> wRasError pulses once on the fifth call; then five returns -> the last four addresses pushed are returned in LIFO order, and the fifth return increments and pulses wRasError.
REQ-040 wStall held 3 cycles while wJumpTaken is high -> wIP holds; in the same cycle both wJumpTaken and wCall are high -> jump wins and the stack is unchanged; Reset together with wStall -> wIP = RESET_VECTOR.
